// File: rtl/mips_harvard_mem_sequencer_pkg.sv
// Shared types and constants for the Harvard-CPU-to-unified-memory sequencer.
package mips_mem_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECIDE,
      ST_DATA,
      ST_COMMIT,
      ST_HALTED
   } mem_seq_state_t;

   localparam logic [3:0]  BYTEEN_WORD      = 4'hF;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;

endpackage

// File: rtl/mips_harvard_mem_sequencer_if.sv
// Unified Avalon-style memory port with wait-request.
interface mips_mem_seq_if;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;

   modport master (
      output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
      input  mem_readdata, mem_waitrequest
   );

   modport slave (
      input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
      output mem_readdata, mem_waitrequest
   );
endinterface

// File: rtl/mips_harvard_mem_sequencer_wait_timer.sv
// Wait-request timeout: down-counter loaded with WAIT_MAX, terminal count at 1.
module mips_wait_timer #(
   parameter int WAIT_MAX = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= CNT_W'(WAIT_MAX);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Expires on the WAIT_MAX-th consecutive stalled cycle; WAIT_MAX=0 never expires.
   generate
      if (WAIT_MAX == 0) begin : g_never
         assign expired_o = 1'b0;
      end else begin : g_tc
         assign expired_o = en_i && (cnt_q == CNT_W'(1));
      end
   endgenerate

endmodule

// File: rtl/mips_harvard_mem_sequencer.sv
// Sequences a Harvard MIPS core onto one unified memory port.
// Optional perf counters enabled by defining MIPS_MEM_SEQ_PERF_EN.
//
// state  | meaning
// IDLE   | out of reset, fetch starts next cycle
// FETCH  | instruction read on the bus
// DECIDE | CPU decodes latched instruction, pick data access
// DATA   | single load or store on the bus
// COMMIT | one-cycle clk_enable to the CPU
// HALTED | stopped (CPU inactive or error), exit only via reset
module mips_harvard_mem_sequencer
   import mips_mem_seq_pkg::*;
#(
   parameter int          WAIT_MAX     = 16,
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_active,
   input  logic [31:0]           cpu_instr_address,
   input  logic [31:0]           cpu_data_address,
   input  logic                  cpu_data_read,
   input  logic                  cpu_data_write,
   input  logic [31:0]           cpu_data_writedata,
   output logic [31:0]           cpu_instr_readdata,
   output logic [31:0]           cpu_data_readdata,
   output logic                  cpu_clk_enable,
   mips_mem_seq_if.master        mem_if,
`ifdef MIPS_MEM_SEQ_PERF_EN
   output logic [31:0]           perf_instr_count,
   output logic [31:0]           perf_stall_count,
`endif
   output logic                  busy,
   output logic                  err
);

   mem_seq_state_t state_q;
   logic [31:0]    instr_q, rdata_q;
   logic           clk_en_q, rd_q, wr_q, busy_q, err_q;
   logic           in_access, stall, expired;
   logic [31:0]    addr_mux, wdata_mux;

   assign in_access = (state_q == ST_FETCH) || (state_q == ST_DATA);
   assign stall     = in_access && mem_if.mem_waitrequest;

   mips_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (state_q == ST_HALTED),
      .load_i    (!in_access),
      .en_i      (stall),
      .expired_o (expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         instr_q  <= '0;
         rdata_q  <= '0;
         clk_en_q <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         clk_en_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // A wrong first address is only flagged; the fetch still goes ahead.
               if (cpu_instr_address != RESET_VECTOR) err_q <= 1'b1;
               rd_q    <= 1'b1;
               busy_q  <= 1'b1;
               state_q <= ST_FETCH;
            end
            ST_FETCH: begin
               if (!mem_if.mem_waitrequest) begin
                  instr_q <= mem_if.mem_readdata;
                  rd_q    <= 1'b0;
                  state_q <= ST_DECIDE;
               end else if (expired) begin
                  err_q   <= 1'b1;
                  rd_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_HALTED;
               end
            end
            ST_DECIDE: begin
               if (cpu_data_read && cpu_data_write) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_HALTED;
               end else if (cpu_data_read || cpu_data_write) begin
                  rd_q    <= cpu_data_read;
                  wr_q    <= cpu_data_write;
                  state_q <= ST_DATA;
               end else begin
                  clk_en_q <= 1'b1;
                  state_q  <= ST_COMMIT;
               end
            end
            ST_DATA: begin
               if (!mem_if.mem_waitrequest) begin
                  if (rd_q) rdata_q <= mem_if.mem_readdata;
                  rd_q     <= 1'b0;
                  wr_q     <= 1'b0;
                  clk_en_q <= 1'b1;
                  state_q  <= ST_COMMIT;
               end else if (expired) begin
                  err_q   <= 1'b1;
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_HALTED;
               end
            end
            ST_COMMIT: begin
               if (cpu_active) begin
                  rd_q    <= 1'b1;
                  state_q <= ST_FETCH;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_HALTED;
               end
            end
            default: begin
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_HALTED;
            end
         endcase
      end
   end

   // The CPU's PC advances on the commit edge, so the fetch address is taken live.
   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      case (state_q)
         ST_FETCH: addr_mux = cpu_instr_address;
         ST_DATA: begin
            addr_mux = cpu_data_address;
            if (wr_q) wdata_mux = cpu_data_writedata;
         end
         default: ;
      endcase
   end

   assign mem_if.mem_address    = addr_mux;
   assign mem_if.mem_read       = rd_q;
   assign mem_if.mem_write      = wr_q;
   assign mem_if.mem_writedata  = wdata_mux;
   assign mem_if.mem_byteenable = (rd_q || wr_q) ? BYTEEN_WORD : 4'h0;

   assign cpu_instr_readdata = instr_q;
   assign cpu_data_readdata  = rdata_q;
   assign cpu_clk_enable     = clk_en_q;
   assign busy               = busy_q;
   assign err                = err_q;

`ifdef MIPS_MEM_SEQ_PERF_EN
   logic [31:0] perf_instr_q, perf_stall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_instr_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (state_q == ST_COMMIT) perf_instr_q <= perf_instr_q + 32'd1;
         if (stall)                perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_instr_count = perf_instr_q;
   assign perf_stall_count = perf_stall_q;
`endif

endmodule

// File: tb/tb_mips_harvard_mem_sequencer.sv
// Directed bench: the bench plays both the CPU and the memory, cycle by cycle.
module tb_mips_harvard_mem_sequencer;

   localparam logic [31:0] RV     = 32'hBFC00000;
   localparam logic [31:0] I_ADDU = 32'h00851021;
   localparam logic [31:0] I_LW   = 32'h8C820200;
   localparam logic [31:0] I_SW   = 32'hAC031000;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_active;
   logic [31:0] cpu_instr_address, cpu_data_address, cpu_data_writedata;
   logic        cpu_data_read, cpu_data_write;
   logic [31:0] cpu_instr_readdata, cpu_data_readdata;
   logic        cpu_clk_enable, busy, err;
`ifdef MIPS_MEM_SEQ_PERF_EN
   logic [31:0] perf_instr_count, perf_stall_count;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic both_seen = 1'b0;

   mips_mem_seq_if mem_bus ();

   mips_harvard_mem_sequencer #(.WAIT_MAX(16), .RESET_VECTOR(RV)) dut (
      .clk                (clk),
      .reset              (reset),
      .cpu_active         (cpu_active),
      .cpu_instr_address  (cpu_instr_address),
      .cpu_data_address   (cpu_data_address),
      .cpu_data_read      (cpu_data_read),
      .cpu_data_write     (cpu_data_write),
      .cpu_data_writedata (cpu_data_writedata),
      .cpu_instr_readdata (cpu_instr_readdata),
      .cpu_data_readdata  (cpu_data_readdata),
      .cpu_clk_enable     (cpu_clk_enable),
      .mem_if             (mem_bus),
`ifdef MIPS_MEM_SEQ_PERF_EN
      .perf_instr_count   (perf_instr_count),
      .perf_stall_count   (perf_stall_count),
`endif
      .busy               (busy),
      .err                (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (mem_bus.mem_read && mem_bus.mem_write) both_seen = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at the FETCH cycle; returns the index of the COMMIT cycle (FETCH=1), or -1.
   task automatic run_instr(input int f_waits, input int d_waits, input logic [31:0] instr,
                            input logic [31:0] rdata, input logic drop_active,
                            output int cycles, output int d_cycles, output int wr_cycles,
                            output int addr_bad, output logic [31:0] wd_seen,
                            output logic [3:0] be_seen);
      int acc = 0, wcnt = 0, lim;
      logic req, prev_req = 1'b0;
      cycles = -1; d_cycles = 0; wr_cycles = 0; addr_bad = 0; wd_seen = '0; be_seen = '0;
      for (int c = 1; c <= 40; c++) begin
         req = mem_bus.mem_read || mem_bus.mem_write;
         if (req && !prev_req) begin acc++; wcnt = 0; end
         mem_bus.mem_waitrequest = 1'b0;
         if (req) begin
            lim = (acc == 1) ? f_waits : d_waits;
            if (acc == 2) begin
               d_cycles++;
               if (mem_bus.mem_write) wr_cycles++;
               if (mem_bus.mem_address !== cpu_data_address) addr_bad++;
               if (drop_active) cpu_active = 1'b0;
            end
            if (wcnt < lim) begin
               mem_bus.mem_waitrequest = 1'b1;
               wcnt++;
            end else begin
               mem_bus.mem_readdata = (acc == 1) ? instr : rdata;
               if (acc == 2) begin
                  wd_seen = mem_bus.mem_writedata;
                  be_seen = mem_bus.mem_byteenable;
               end
            end
         end
         if (cpu_clk_enable) begin
            cycles = c;
            break;
         end
         prev_req = req;
         step();
      end
   endtask

   initial begin
      int cyc, dcyc, wrc, abad, cnt;
      logic [31:0] wd;
      logic [3:0]  be;

      reset = 1'b1; cpu_active = 1'b1;
      cpu_instr_address = RV; cpu_data_address = '0; cpu_data_writedata = '0;
      cpu_data_read = 1'b0; cpu_data_write = 1'b0;
      mem_bus.mem_readdata = '0; mem_bus.mem_waitrequest = 1'b0;
      step(); step();
      chk("rst_mem_read",  32'(mem_bus.mem_read), 0);
      chk("rst_mem_write", 32'(mem_bus.mem_write), 0);
      chk("rst_mem_addr",  mem_bus.mem_address, 0);
      chk("rst_clk_en",    32'(cpu_clk_enable), 0);
      chk("rst_err_busy",  {30'd0, err, busy}, 0);
      chk("rst_rdata",     cpu_instr_readdata | cpu_data_readdata, 0);

      // addu, zero wait
      reset = 1'b0;
      step();
      chk("addu_fetch_rd",   32'(mem_bus.mem_read), 1);
      chk("addu_fetch_addr", mem_bus.mem_address, RV);
      chk("addu_fetch_be",   32'(mem_bus.mem_byteenable), 32'hF);
      chk("addu_busy",       32'(busy), 1);
      run_instr(0, 0, I_ADDU, 0, 1'b0, cyc, dcyc, wrc, abad, wd, be);
      chk("addu_latency", cyc, 3);
      chk("addu_instr",   cpu_instr_readdata, I_ADDU);
      chk("addu_no_data", dcyc, 0);
      chk("addu_err",     32'(err), 0);

      // lw with two data waits
      cpu_instr_address = RV + 4; cpu_data_read = 1'b1; cpu_data_address = 32'h0000_0200;
      step();
      run_instr(0, 2, I_LW, 32'h2222_2222, 1'b0, cyc, dcyc, wrc, abad, wd, be);
      chk("lw_latency",  cyc, 6);
      chk("lw_rdata",    cpu_data_readdata, 32'h2222_2222);
      chk("lw_dcycles",  dcyc, 3);
      chk("lw_addr_bad", abad, 0);
      chk("lw_no_write", wrc, 0);

      // sw, zero wait
      cpu_instr_address = RV + 8; cpu_data_read = 1'b0; cpu_data_write = 1'b1;
      cpu_data_address = 32'h0000_1000; cpu_data_writedata = 32'h3333_3333;
      step();
      run_instr(0, 0, I_SW, 32'hDEAD_BEEF, 1'b0, cyc, dcyc, wrc, abad, wd, be);
      chk("sw_latency", cyc, 4);
      chk("sw_wr_cyc",  wrc, 1);
      chk("sw_wdata",   wd, 32'h3333_3333);
      chk("sw_be",      32'(be), 32'hF);
      chk("sw_addr_bad", abad, 0);
      chk("sw_rdata_hold", cpu_data_readdata, 32'h2222_2222);

      // lw where cpu_active drops during DATA
      cpu_instr_address = RV + 12; cpu_data_write = 1'b0; cpu_data_read = 1'b1;
      cpu_data_address = 32'h0000_0300;
      step();
      run_instr(1, 1, I_LW, 32'h4444_4444, 1'b1, cyc, dcyc, wrc, abad, wd, be);
      chk("drop_latency", cyc, 6);
      chk("drop_rdata",   cpu_data_readdata, 32'h4444_4444);
      step();
      chk("drop_busy", 32'(busy), 0);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (mem_bus.mem_read || mem_bus.mem_write || cpu_clk_enable) cnt++;
         step();
      end
      chk("drop_quiet", cnt, 0);

      // read and write together in DECIDE
      reset = 1'b1; cpu_active = 1'b1; cpu_instr_address = RV;
      cpu_data_read = 1'b1; cpu_data_write = 1'b1;
      step();
      reset = 1'b0;
      step(); step(); step();
      chk("both_err",  32'(err), 1);
      chk("both_busy", 32'(busy), 0);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (mem_bus.mem_read || mem_bus.mem_write || cpu_clk_enable) cnt++;
         step();
      end
      chk("both_quiet", cnt, 0);

      // fetch timeout
      reset = 1'b1; cpu_data_read = 1'b0; cpu_data_write = 1'b0;
      mem_bus.mem_waitrequest = 1'b1;
      step();
      chk("to_rst_err", 32'(err), 0);
      reset = 1'b0;
      step();
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (mem_bus.mem_read) cnt++;
         step();
      end
      chk("to_read_cycles", cnt, 16);
      chk("to_err",  32'(err), 1);
      chk("to_drop", 32'(mem_bus.mem_read), 0);

      // recover through reset with a wrong first address (warning only)
      reset = 1'b1; mem_bus.mem_waitrequest = 1'b0; cpu_instr_address = 32'h0000_0000;
      #1;
      chk("rec_err_clr", 32'(err), 0);
      step();
      reset = 1'b0;
      step();
      chk("rv_err_set", 32'(err), 1);
      chk("rv_fetch_addr", mem_bus.mem_address, 32'h0000_0000);
      run_instr(0, 0, I_ADDU, 0, 1'b0, cyc, dcyc, wrc, abad, wd, be);
      chk("rv_latency", cyc, 3);
      chk("rv_err_sticky", 32'(err), 1);

      // reset in the middle of a stalled fetch
      mem_bus.mem_waitrequest = 1'b1;
      step(); step();
      chk("mid_rd_before", 32'(mem_bus.mem_read), 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rd_drop", 32'(mem_bus.mem_read), 0);
      chk("mid_busy",    32'(busy), 0);
      step();

      chk("never_rd_wr", 32'(both_seen), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mips_harvard_mem_sequencer.md
Name: mips_harvard_mem_sequencer

Overview:
- Sequences one mips_cpu_harvard instance onto a single unified memory port with wait-request.
- Per instruction, in order: fetches the instruction word, latches it and presents it on the CPU's combinational instr_readdata, performs at most one data access, latches read data, then pulses the CPU clk_enable for one cycle to commit.
- Sits between the CPU and the Avalon-style memory/bus wrapper, in the top-level CPU-plus-memory integration.

Parameters:
- WAIT_MAX, 16, max consecutive waitrequest cycles per access before error; 0 disables the timeout.
- RESET_VECTOR, 32'hBFC00000, expected first instr_address; mismatch on first fetch sets err.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- cpu_active  in  1  CPU active output
- cpu_instr_address  in  32  CPU fetch address
- cpu_data_address  in  32  CPU data address
- cpu_data_read  in  1  CPU load request
- cpu_data_write  in  1  CPU store request
- cpu_data_writedata  in  32  CPU store data
- cpu_instr_readdata  out  32  latched instruction to CPU
- cpu_data_readdata  out  32  latched load data to CPU
- cpu_clk_enable  out  1  CPU commit strobe
- mem_address  out  32  unified memory address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_writedata  out  32  memory write data
- mem_byteenable  out  4  always 4'hF when mem_read or mem_write is high, else 0
- mem_readdata  in  32  memory read data
- mem_waitrequest  in  1  memory stall
- busy  out  1  high in every state except IDLE and HALTED
- err  out  1  sticky error flag

Behaviour:
- Reset (async, active-high): state IDLE.
  - All outputs 0: cpu_instr_readdata, cpu_data_readdata, cpu_clk_enable, mem_read, mem_write, mem_address, err, busy.
  - Reset asserted mid-access drops mem_read/mem_write immediately; the bus wrapper discards the access.
- States: IDLE, FETCH, DECIDE, DATA, COMMIT, HALTED.
- IDLE: on the first clk edge with reset low -> FETCH.
- FETCH:
  - Drives mem_read=1 and mem_address=cpu_instr_address.
  - While mem_waitrequest=1: hold the request stable and count wait cycles.
  - When mem_waitrequest=0: cpu_instr_readdata<=mem_readdata, go to DECIDE.
- DECIDE: mem idle; CPU control outputs settle on the new instruction.
  - cpu_data_read XOR cpu_data_write -> DATA.
  - Both asserted -> err=1, go to HALTED.
  - Neither asserted -> COMMIT.
- DATA:
  - Drives mem_address=cpu_data_address, mem_read=cpu_data_read, mem_write=cpu_data_write, mem_writedata=cpu_data_writedata.
  - Completes on mem_waitrequest=0. On a read, cpu_data_readdata<=mem_readdata; cpu_data_readdata holds its old value on a write.
  - Then -> COMMIT.
- COMMIT: cpu_clk_enable=1 for exactly this one cycle, then:
  - cpu_active=1 -> FETCH.
  - cpu_active=0 -> HALTED.
- HALTED: all requests low and cpu_clk_enable=0. Exit only via reset.
- Timeout: the wait counter resets at the start of each access. Reaching WAIT_MAX cycles of consecutive waitrequest sets err=1, drops the request and goes to HALTED.
- First fetch after reset: cpu_instr_address != RESET_VECTOR sets err=1 but the fetch proceeds (warning only).
- Latency with zero wait states:
  - Non-memory instruction: 3 cycles (FETCH, DECIDE, COMMIT).
  - Load/store: 4 cycles.
  - Each waitrequest cycle adds 1.
- mem_read and mem_write are never high together. The request is asserted only in FETCH and DATA.

Optional Feature:
- Macro: MIPS_MEM_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_instr_count[31:0] (+1 per COMMIT) and perf_stall_count[31:0] (+1 per waitrequest cycle in FETCH/DATA).
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent; no other behavioural difference.

Decomposition:
- Package mips_mem_seq_pkg holds:
  - the state enum mem_seq_state_t;
  - localparam BYTEEN_WORD=4'hF;
  - the default RESET_VECTOR constant.
- One sub-module, mips_wait_timer: loadable counter with clear, enable and expired outputs, parameterised by WAIT_MAX, 0 = never expires.

Test Plan:
- Reset, then addu with zero-wait memory -> mem_read at 0xBFC00000; cpu_clk_enable pulses exactly 3 cycles after leaving IDLE; mem_write never asserted.
- lw returning 0x22222222 with 2 waitrequest cycles in DATA -> cpu_data_readdata=0x22222222, commit 6 cycles after FETCH entry, mem_address=cpu_data_address during DATA.
- sw of 0x33333333 to 0x00001000 -> mem_write=1 for one zero-wait cycle with mem_writedata=0x33333333 and mem_byteenable=4'hF; cpu_data_readdata unchanged.
- cpu_data_read and cpu_data_write both high in DECIDE -> err=1, HALTED, no COMMIT pulse, no memory requests afterward.
- mem_waitrequest stuck high in FETCH with WAIT_MAX=16 -> err=1 after 16 cycles, mem_read drops; reset then recovers to IDLE with err=0.
- cpu_active drops during DATA -> that access completes and COMMIT pulses once, then HALTED; busy=0 and no further fetch.
